// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller with all-red clearance, pedestrian walk phase and a
// night flashing mode. Lamp outputs are decoded directly from the state register.
module traffic_light_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned GREEN_T  = 8,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned RED_T    = 2,
  parameter int unsigned PED_T    = 5,
  parameter int unsigned FLASH_T  = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       hold,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [0:2] light_a,
  output logic [0:2] light_b,
  output logic       walk,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StAGreen  = 3'd0,
    StAYellow = 3'd1,
    StAllRed1 = 3'd2,
    StBGreen  = 3'd3,
    StBYellow = 3'd4,
    StAllRed2 = 3'd5,
    StWalk    = 3'd6,
    StFlash   = 3'd7
  } state_e;

  localparam logic [0:2] LampRed    = 3'b100;
  localparam logic [0:2] LampGreen  = 3'b010;
  localparam logic [0:2] LampYellow = 3'b001;
  localparam logic [0:2] LampOff    = 3'b000;

  // Durations are truncated to the timer width first; a zero duration behaves as one cycle.
  localparam logic [CNT_W-1:0] GreenTr  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] YellowTr = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] RedTr    = CNT_W'(RED_T);
  localparam logic [CNT_W-1:0] PedTr    = CNT_W'(PED_T);
  localparam logic [CNT_W-1:0] FlashTr  = CNT_W'(FLASH_T);

  localparam logic [CNT_W-1:0] GreenLd  = (GreenTr  == '0) ? '0 : GreenTr  - 1'b1;
  localparam logic [CNT_W-1:0] YellowLd = (YellowTr == '0) ? '0 : YellowTr - 1'b1;
  localparam logic [CNT_W-1:0] RedLd    = (RedTr    == '0) ? '0 : RedTr    - 1'b1;
  localparam logic [CNT_W-1:0] PedLd    = (PedTr    == '0) ? '0 : PedTr    - 1'b1;
  localparam logic [CNT_W-1:0] FlashLd  = (FlashTr  == '0) ? '0 : FlashTr  - 1'b1;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic             r_ped, w_ped_nxt;
  logic             r_flash_on, w_flash_on_nxt;
  logic             w_expire;

  function automatic logic [CNT_W-1:0] load_for(input state_e st);
    logic [CNT_W-1:0] v;
    case (st)
      StAGreen, StBGreen:   v = GreenLd;
      StAYellow, StBYellow: v = YellowLd;
      StAllRed1, StAllRed2: v = RedLd;
      StWalk:               v = PedLd;
      default:              v = FlashLd;
    endcase
    return v;
  endfunction

  assign w_expire = (r_timer == '0) && !hold;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= StAllRed2;
      r_timer    <= RedLd;
      r_ped      <= 1'b0;
      r_flash_on <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_ped      <= w_ped_nxt;
      r_flash_on <= w_flash_on_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StAGreen:  if (w_expire) w_state_nxt = StAYellow;
      StAYellow: if (w_expire) w_state_nxt = StAllRed1;
      StAllRed1: if (w_expire) w_state_nxt = flash_mode ? StFlash : StBGreen;
      StBGreen:  if (w_expire) w_state_nxt = StBYellow;
      StBYellow: if (w_expire) w_state_nxt = StAllRed2;
      StAllRed2: begin
        if (w_expire) begin
          if (flash_mode)  w_state_nxt = StFlash;
          else if (r_ped)  w_state_nxt = StWalk;
          else             w_state_nxt = StAGreen;
        end
      end
      StWalk:    if (w_expire) w_state_nxt = StAGreen;
      // Leaving flash ignores hold and the current flash phase.
      StFlash:   if (!flash_mode) w_state_nxt = StAllRed2;
      default:   w_state_nxt = StAllRed2;
    endcase
  end

  always_comb begin
    w_timer_nxt    = r_timer;
    w_flash_on_nxt = r_flash_on;
    if (w_state_nxt != r_state) begin
      w_timer_nxt    = load_for(w_state_nxt);
      w_flash_on_nxt = 1'b1;
    end else if (!hold) begin
      if (r_state == StFlash && r_timer == '0) begin
        w_timer_nxt    = FlashLd;
        w_flash_on_nxt = ~r_flash_on;
      end else begin
        w_timer_nxt = r_timer - 1'b1;
      end
    end

    w_ped_nxt = r_ped;
    if (w_state_nxt == StWalk && r_state != StWalk) begin
      w_ped_nxt = 1'b0;
    end else if (ped_req && r_state != StWalk) begin
      w_ped_nxt = 1'b1;
    end
  end

  always_comb begin
    light_a = LampRed;
    light_b = LampRed;
    walk    = 1'b0;
    state_o = r_state;
    unique case (r_state)
      StAGreen:  light_a = LampGreen;
      StAYellow: light_a = LampYellow;
      StBGreen:  light_b = LampGreen;
      StBYellow: light_b = LampYellow;
      StWalk:    walk    = 1'b1;
      StFlash: begin
        light_a = r_flash_on ? LampYellow : LampOff;
        light_b = r_flash_on ? LampYellow : LampOff;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of phase timer.
REQ-002 Parameter GREEN_T, default 8: green duration in cycles.
REQ-003 Parameter YELLOW_T, default 3: yellow duration in cycles.
REQ-004 Parameter RED_T, default 2: all-red clearance duration in cycles.
REQ-005 Parameter PED_T, default 5: pedestrian walk duration in cycles.
REQ-006 Parameter FLASH_T, default 4: flash half-period in cycles.
REQ-007 Port clock, input, 1: single clock, all state updates on rising edge.
REQ-008 Port reset_n, input, 1: synchronous, active-low reset.
REQ-009 Port hold, input, 1: 1 freezes the timer and the state.
REQ-010 Port ped_req, input, 1: pedestrian request, single-cycle pulse or level.
REQ-011 Port flash_mode, input, 1: 1 requests night flashing mode.
REQ-012 Port light_a, output, [0:2]: main road lamp, Red=100, Green=010, Yellow=001.
REQ-013 Port light_b, output, [0:2]: side road lamp, same encoding.
REQ-014 Port walk, output, 1: pedestrian walk indicator.
REQ-015 Port state_o, output, 3: current state code.

Function
REQ-016 States and codes: A_GREEN=0, A_YELLOW=1, ALL_RED1=2, B_GREEN=3, B_YELLOW=4, ALL_RED2=5, WALK=6, FLASH=7.
REQ-017 Outputs decode from the state register only (Moore), with no extra latency: light_a/light_b/walk change on the same edge as the state.
REQ-018 Lamp decode:
- A_GREEN: a=Green, b=Red.
- A_YELLOW: a=Yellow, b=Red.
- B_GREEN: a=Red, b=Green.
- B_YELLOW: a=Red, b=Yellow.
- ALL_RED1, ALL_RED2, WALK: both Red.
- walk=1 only in WALK.
REQ-019 On state entry, the timer loads duration-1; the state advances on the edge where the timer equals 0 and hold=0; otherwise the timer decrements when hold=0. Each state therefore lasts exactly its duration.
REQ-020 Durations of 0 are treated as 1; all durations are truncated to CNT_W bits.
REQ-021 Fixed transitions: A_GREEN->A_YELLOW->ALL_RED1, and B_GREEN->B_YELLOW->ALL_RED2.
REQ-022 ALL_RED1 expiry: flash_mode=1 -> FLASH, else B_GREEN.
REQ-023 ALL_RED2 expiry priority: flash_mode=1 -> FLASH; else ped_pending=1 -> WALK; else A_GREEN.
REQ-024 WALK expiry -> A_GREEN.
REQ-025 ped_pending:
- Set by ped_req=1 in any state except WALK.
- Cleared on entry to WALK.
- Retained through hold and FLASH.
- ped_req=1 on the entry edge to WALK does not set it.
REQ-026 flash_mode is sampled only at ALL_RED1/ALL_RED2 expiry; a green or yellow phase always completes normally.
REQ-027 FLASH behaviour:
- light_a = light_b = Yellow during the on half-period and 000 during the off half-period.
- Starts with the on half; toggles every FLASH_T cycles.
- walk=0.
REQ-028 FLASH exit: in FLASH, flash_mode=0 -> ALL_RED2 on the next edge, timer loaded with RED_T-1, regardless of flash phase.
REQ-029 hold=1 freezes the state, timer and flash phase; ped_pending still latches; in FLASH, hold does not block exit.
REQ-030 hold and timer expiry in the same cycle: hold wins, no transition.

Reset
REQ-031 reset_n=0 at an edge forces state ALL_RED2, timer=RED_T-1, ped_pending=0, flash phase=on. This gives light_a=light_b=100, walk=0, state_o=5.
REQ-032 Reset takes priority over every other input and applies mid-phase, including during WALK and FLASH.

Verification
REQ-033 Defaults, reset released, no requests -> ALL_RED2 for 2 cycles, A_GREEN 8, A_YELLOW 3, ALL_RED1 2, B_GREEN 8, B_YELLOW 3, ALL_RED2 2; period is 26 cycles.
REQ-034 ped_req pulsed during B_GREEN -> after ALL_RED2, WALK for 5 cycles with walk=1 and both lamps 100, then A_GREEN; the next cycle has no WALK.
REQ-035 flash_mode=1 raised during A_GREEN -> A_GREEN, A_YELLOW and ALL_RED1 complete, then FLASH with both lamps toggling 001/000 every 4 cycles; flash_mode=0 -> ALL_RED2 for 2 cycles -> A_GREEN.
REQ-036 hold=1 for 10 cycles mid B_GREEN -> state_o stays 3 throughout, and total B_GREEN time is 18 cycles.
REQ-037 reset_n=0 for one cycle during WALK -> next state_o=5, walk=0, ped_pending cleared, and A_GREEN follows after 2 cycles.
REQ-038 ped_req and flash_mode both 1 at ALL_RED2 expiry -> FLASH entered; ped_pending is retained, and WALK is served after flash exit and ALL_RED2.
